// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between two requesters,
// with per-port lock for atomic read-modify-write and tagged read-valid return.
module sram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_gnt,
    output logic              a_rvalid,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              sram_csb_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    typedef enum logic [1:0] {
        LOCK_IDLE  = 2'd0,
        LOCK_OWN_A = 2'd1,
        LOCK_OWN_B = 2'd2
    } lock_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    lock_state_t lock_state;
    logic        rr_last;
    logic        rd_pend;
    logic        rd_port;

    logic        own_a;
    logic        own_b;
    logic        gnt_a;
    logic        gnt_b;

    // Ownership ends in the very cycle the owner drops its lock, so the other
    // port can already be granted in that cycle.
    assign own_a = (lock_state == LOCK_OWN_A) && a_lock;
    assign own_b = (lock_state == LOCK_OWN_B) && b_lock;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (reset) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end else if (own_a) begin
            gnt_a = a_req;
        end else if (own_b) begin
            gnt_b = b_req;
        end else if (a_req && b_req) begin
            gnt_a = (rr_last == PORT_B);
            gnt_b = (rr_last == PORT_A);
        end else begin
            gnt_a = a_req;
            gnt_b = b_req;
        end
    end

    assign a_gnt = gnt_a;
    assign b_gnt = gnt_b;

    always_comb begin
        sram_csb_n = 1'b1;
        sram_we_n  = 1'b1;
        sram_addr  = '0;
        sram_din   = '0;
        if (gnt_a) begin
            sram_csb_n = 1'b0;
            sram_we_n  = ~a_we;
            sram_addr  = a_addr;
            sram_din   = a_wdata;
        end else if (gnt_b) begin
            sram_csb_n = 1'b0;
            sram_we_n  = ~b_we;
            sram_addr  = b_addr;
            sram_din   = b_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state <= LOCK_IDLE;
            rr_last    <= PORT_B;
            rd_pend    <= 1'b0;
            rd_port    <= PORT_A;
        end else begin
            if (gnt_a) begin
                rr_last <= PORT_A;
            end else if (gnt_b) begin
                rr_last <= PORT_B;
            end

            if (gnt_a && a_lock) begin
                lock_state <= LOCK_OWN_A;
            end else if (gnt_b && b_lock) begin
                lock_state <= LOCK_OWN_B;
            end else if (own_a) begin
                lock_state <= LOCK_OWN_A;
            end else if (own_b) begin
                lock_state <= LOCK_OWN_B;
            end else begin
                lock_state <= LOCK_IDLE;
            end

            rd_pend <= (gnt_a && !a_we) || (gnt_b && !b_we);
            rd_port <= gnt_b ? PORT_B : PORT_A;
        end
    end

    assign a_rvalid = rd_pend && (rd_port == PORT_A);
    assign b_rvalid = rd_pend && (rd_port == PORT_B);
    assign rdata    = sram_dout;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a vector table plus hand-written
// idle and reset-during-read sequences, against a behavioural 32x32 SRAM.
module tb_sram_port_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              a_req, a_we, a_lock, a_gnt, a_rvalid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] rdata;
    logic              sram_csb_n, sram_we_n;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    int total = 0;
    int bad   = 0;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_lock     (a_lock),
        .a_gnt      (a_gnt),
        .a_rvalid   (a_rvalid),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_lock     (b_lock),
        .b_gnt      (b_gnt),
        .b_rvalid   (b_rvalid),
        .rdata      (rdata),
        .sram_csb_n (sram_csb_n),
        .sram_we_n  (sram_we_n),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port macro: synchronous write, registered read.
    logic [DATA_W-1:0] mem [0:31];
    always @(posedge clk) begin
        if (!sram_csb_n) begin
            if (!sram_we_n) mem[sram_addr] <= sram_din;
            else            sram_dout      <= mem[sram_addr];
        end
    end

    typedef struct {
        logic              a_req, a_we, a_lock;
        logic [ADDR_W-1:0] a_addr;
        logic [DATA_W-1:0] a_wdata;
        logic              b_req, b_we, b_lock;
        logic [ADDR_W-1:0] b_addr;
        logic [DATA_W-1:0] b_wdata;
        logic [1:0]        gnt;     // {a_gnt, b_gnt}
        logic [1:0]        rv;      // {a_rvalid, b_rvalid}
        logic              csb_n, we_n;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] rdata;   // checked only when an rvalid is expected
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ar, input logic aw, input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] ad, input logic al,
                       input logic br, input logic bw, input logic [ADDR_W-1:0] ba,
                       input logic [DATA_W-1:0] bd, input logic bl,
                       input logic [1:0] g, input logic [1:0] r, input logic cs, input logic we,
                       input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                       input logic [DATA_W-1:0] erd);
        vec_t v;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad; v.a_lock = al;
        v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd; v.b_lock = bl;
        v.gnt = g; v.rv = r; v.csb_n = cs; v.we_n = we; v.addr = ea; v.din = ed; v.rdata = erd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_lock = 0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0;
    endtask

    task automatic check_bus(input string tag, input logic [1:0] g, input logic [1:0] r,
                             input logic cs, input logic we);
        check({tag, " a_gnt"},      a_gnt,      g[1]);
        check({tag, " b_gnt"},      b_gnt,      g[0]);
        check({tag, " a_rvalid"},   a_rvalid,   r[1]);
        check({tag, " b_rvalid"},   b_rvalid,   r[0]);
        check({tag, " sram_csb_n"}, sram_csb_n, cs);
        check({tag, " sram_we_n"},  sram_we_n,  we);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        mem[5] = 32'hDEAD_BEEF;
        sram_dout = '0;
        drive_idle();
        reset = 1'b1;

        //  A: req we addr wdata lock | B: req we addr wdata lock | gnt rv csb we addr din rdata
        add(0,0, 0,32'h0,0,          0,0, 0,32'h0,0,  2'b00,2'b00,1,1, 0,32'h0,32'h0);            // reset state
        add(1,0, 1,32'h0,0,          1,0, 2,32'h0,0,  2'b10,2'b00,0,1, 1,32'h0,32'h0);            // tie: A first
        add(1,0, 1,32'h0,0,          1,0, 2,32'h0,0,  2'b01,2'b10,0,1, 2,32'h0,32'h1000_0001);
        add(1,0, 1,32'h0,0,          1,0, 2,32'h0,0,  2'b10,2'b01,0,1, 1,32'h0,32'h1000_0002);
        add(1,0, 1,32'h0,0,          1,0, 2,32'h0,0,  2'b01,2'b10,0,1, 2,32'h0,32'h1000_0001);
        add(0,0, 0,32'h0,0,          0,0, 0,32'h0,0,  2'b00,2'b01,1,1, 0,32'h0,32'h1000_0002);
        add(1,0, 5,32'h0,0,          0,0, 0,32'h0,0,  2'b10,2'b00,0,1, 5,32'h0,32'h0);            // A read 5
        add(0,0, 0,32'h0,0,          1,1,31,32'h1234_5678,0, 2'b01,2'b10,0,0,31,32'h1234_5678,32'hDEAD_BEEF);
        add(1,0,31,32'h0,0,          0,0, 0,32'h0,0,  2'b10,2'b00,0,1,31,32'h0,32'h0);            // write: no rvalid
        add(0,0, 0,32'h0,0,          1,0, 0,32'h0,0,  2'b01,2'b10,0,1, 0,32'h0,32'h1234_5678);
        add(1,0, 3,32'h0,1,          1,0, 4,32'h0,0,  2'b10,2'b01,0,1, 3,32'h0,32'h1000_0000);    // A locks
        add(1,1, 3,32'hCAFE_F00D,1,  1,0, 4,32'h0,0,  2'b10,2'b10,0,0, 3,32'hCAFE_F00D,32'h1000_0003);
        add(0,0, 0,32'h0,1,          1,0, 4,32'h0,0,  2'b00,2'b00,1,1, 0,32'h0,32'h0);            // owner idle
        add(0,0, 0,32'h0,0,          1,0, 4,32'h0,0,  2'b01,2'b00,0,1, 4,32'h0,32'h0);            // lock drops
        add(0,0, 0,32'h0,0,          1,0, 3,32'h0,0,  2'b01,2'b01,0,1, 3,32'h0,32'h1000_0004);
        add(0,0, 0,32'h0,0,          0,0, 0,32'h0,0,  2'b00,2'b01,1,1, 0,32'h0,32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr;
            a_wdata = vecs[i].a_wdata; a_lock = vecs[i].a_lock;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr;
            b_wdata = vecs[i].b_wdata; b_lock = vecs[i].b_lock;
            @(negedge clk);
            check_bus(tag, vecs[i].gnt, vecs[i].rv, vecs[i].csb_n, vecs[i].we_n);
            check({tag, " sram_addr"}, 32'(sram_addr), 32'(vecs[i].addr));
            check({tag, " sram_din"},  sram_din,       vecs[i].din);
            if (vecs[i].rv != 2'b00) check({tag, " rdata"}, rdata, vecs[i].rdata);
            @(posedge clk);
            #1;
        end

        // Ten idle cycles: macro deselected, nothing granted or returned.
        drive_idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_bus($sformatf("idle%0d", c), 2'b00, 2'b00, 1'b1, 1'b1);
            @(posedge clk);
            #1;
        end

        // Reset in the cycle after an A read grant: no rvalid, grants forced off.
        a_req = 1; a_addr = 5;
        @(negedge clk);
        check("rst pre a_gnt", a_gnt, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        b_req = 1; b_addr = 7;
        @(negedge clk);
        check_bus("rst", 2'b00, 2'b00, 1'b1, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_bus("post rst tie", 2'b10, 2'b00, 1'b0, 1'b1);
        check("post rst addr", 32'(sram_addr), 32'd5);
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        check("post rst a_rvalid", a_rvalid, 1'b1);
        check("post rst rdata", rdata, 32'hDEAD_BEEF);
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
